// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Stall/flush sequencer for the 5-stage MIPS pipeline. It has no datapath of
//   its own. It drives the load enables and bubble inserts for PC, IF/ID,
//   ID/EX, EX/MEM and MEM/WB from four causes:
//     - load-use hazards
//     - taken branches resolved in EX
//     - variable-latency data-memory accesses
//     - multi-cycle mul/div operations
//
//   Ports:
//     clk, reset            rising-edge clock, async active-high reset
//     id_rs/id_rt/id_uses_rt          source operands of the ID instruction
//     ex_mem_read/ex_write_reg        load in EX and its destination register
//     ex_branch_taken, ex_muldiv_start  EX-stage control events
//     mem_req/mem_ready               data-memory handshake of the MEM stage
//     *_write / *_flush               per-register load enable / bubble insert
//     muldiv_done           one-cycle pulse when the mul/div result is valid
//     busy                  high in MEM_WAIT or MULDIV_BUSY
//     stall_cycle_count, flush_count  performance counters
//
//   Optional feature: define HAZARD_PERF_COUNTERS_EN to build the saturating
//   counters. When it is undefined, both counter ports are tied to zero.
module pipeline_hazard_controller #(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_write_reg,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_start,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_write,
    output logic             memwb_flush,
    output logic             muldiv_done,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycle_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MULDIV_BUSY} state_t;

    // The entry cycle in RUN is the first freeze cycle. That is why the
    // counter starts one below the total.
    localparam logic [3:0] MD_INIT = 4'(MULDIV_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       load_use, do_mem, do_freeze, done;

    assign load_use = ex_mem_read && (ex_write_reg != 5'd0) &&
                      ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        do_mem      = 1'b0;
        do_freeze   = 1'b0;
        done        = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    do_mem    = 1'b1;
                    state_nxt = MEM_WAIT;
                end else if (ex_muldiv_start) begin
                    do_freeze = 1'b1;
                    cnt_nxt   = MD_INIT;
                    state_nxt = MULDIV_BUSY;
                end
            end
            MEM_WAIT: begin
                // ex_muldiv_start is ignored here. The held EX instruction
                // raises it again once the pipeline is back in RUN.
                if (!mem_ready) do_mem = 1'b1;
                else            state_nxt = RUN;
            end
            MULDIV_BUSY: begin
                // MEM holds bubbles while frozen, so mem_req is ignored.
                if (cnt != 4'd0) begin
                    do_freeze = 1'b1;
                    cnt_nxt   = cnt - 4'd1;
                end else begin
                    done      = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        exmem_flush = 1'b0;
        memwb_write = 1'b1;
        memwb_flush = 1'b0;
        muldiv_done = done;
        busy        = (state != RUN);

        if (do_mem) begin
            // Hold PC through EX/MEM. Drain a bubble into WB.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
        end else if (do_freeze) begin
            // Hold the front end. A bubble leaves EX while the unit iterates.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            // A taken branch squashes the wrong-path instructions. It also
            // overrides any load-use stall on them.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
        end

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_write  = 1'b0;
            idex_flush  = 1'b0;
            exmem_write = 1'b0;
            exmem_flush = 1'b0;
            memwb_write = 1'b0;
            memwb_flush = 1'b0;
            muldiv_done = 1'b0;
            busy        = 1'b0;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // The flops are in reset while reset is high, so only live cycles count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycle_count = stall_q;
    assign flush_count       = flush_q;
`else
    assign stall_cycle_count = '0;
    assign flush_count       = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;
    localparam int MDC = 4;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_write_reg = '0;
    logic id_uses_rt = 0, ex_mem_read = 0, ex_branch_taken = 0, ex_muldiv_start = 0;
    logic mem_req = 0, mem_ready = 0;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, exmem_flush, memwb_write, memwb_flush, muldiv_done, busy;
    logic [CW-1:0] stall_cycle_count, flush_count;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MULDIV_CYCLES(MDC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush),
        .exmem_write(exmem_write), .exmem_flush(exmem_flush),
        .memwb_write(memwb_write), .memwb_flush(memwb_flush),
        .muldiv_done(muldiv_done), .busy(busy),
        .stall_cycle_count(stall_cycle_count), .flush_count(flush_count));

    int n_chk = 0;
    int n_fail = 0;

    // Reference model. waiting_mem means a memory access is still pending.
    // md_left is the number of freeze cycles still owed after the entry
    // cycle, or -1 when no mul/div is in progress.
    bit waiting_mem = 0;
    int md_left = -1;
    logic [CW-1:0] m_stall = '0, m_flush = '0;

    // Bit order: {pc,ifid_w,ifid_f,idex_w,idex_f,exmem_w,exmem_f,memwb_w,memwb_f,done,busy}
    localparam logic [8:0] MEMSTALL = 9'b0_0_0_0_0_0_0_1_1;
    localparam logic [8:0] FREEZE   = 9'b0_0_0_0_0_1_1_1_0;

    function automatic logic [10:0] model_outs();
        logic [8:0] w;
        bit lu, idle, bsy, dn;
        if (reset) return 11'd0;
        lu = ex_mem_read && ex_write_reg != 0 &&
             (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt));
        idle = !waiting_mem && md_left < 0;
        bsy  = !idle;
        dn   = 0;
        if (waiting_mem && !mem_ready)                 w = MEMSTALL;
        else if (md_left > 0)                          w = FREEZE;
        else if (idle && mem_req && !mem_ready)        w = MEMSTALL;
        else if (idle && ex_muldiv_start)              w = FREEZE;
        else begin
            dn = (md_left == 0);
            w  = 9'b1_1_0_1_0_1_0_1_0;
            if (ex_branch_taken) begin w[6] = 1; w[4] = 1; end
            else if (lu)         begin w[8] = 0; w[7] = 0; w[4] = 1; end
        end
        return {w, dn, bsy};
    endfunction

    always @(posedge clk) begin
        logic [10:0] e;
        e = model_outs();
        if (reset) begin
            waiting_mem = 0; md_left = -1; m_stall = '0; m_flush = '0;
        end else begin
`ifdef HAZARD_PERF_COUNTERS_EN
            if (!e[10] && m_stall != '1) m_stall = m_stall + 1;
            if (e[8] && m_flush != '1)   m_flush = m_flush + 1;
`endif
            if (waiting_mem)                 begin if (mem_ready) waiting_mem = 0; end
            else if (md_left > 0)            md_left = md_left - 1;
            else if (md_left == 0)           md_left = -1;
            else if (mem_req && !mem_ready)  waiting_mem = 1;
            else if (ex_muldiv_start)        md_left = MDC - 1;
        end
    end

    task automatic check_model();
        logic [10:0] e, a;
        e = model_outs();
        a = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
             exmem_flush, memwb_write, memwb_flush, muldiv_done, busy};
        n_chk += 3;
        if (a !== e) begin
            n_fail++;
            $display("FAIL outs t=%0t actual=%b required=%b", $time, a, e);
        end
        if (stall_cycle_count !== m_stall) begin
            n_fail++;
            $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, stall_cycle_count, m_stall);
        end
        if (flush_count !== m_flush) begin
            n_fail++;
            $display("FAIL flush_cnt t=%0t actual=%0d required=%0d", $time, flush_count, m_flush);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // ctl = {reset, uses_rt, mem_read, branch, muldiv, mem_req, mem_ready}
    task automatic go(input logic [6:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] wr);
        @(negedge clk);
        {reset, id_uses_rt, ex_mem_read, ex_branch_taken, ex_muldiv_start, mem_req, mem_ready} = ctl;
        id_rs = rs; id_rt = rt; ex_write_reg = wr;
        #1 check_model();
    endtask

    task automatic do_reset();
        go(7'b1000000, 0, 0, 0);
        lit("rst_pc", pc_write, 0);
        lit("rst_busy", busy, 0);
        lit("rst_memwb_w", memwb_write, 0);
        lit("rst_stall_cnt", stall_cycle_count, 0);
    endtask

    initial begin
        do_reset();
        go(7'b0000000, 0, 0, 0);
        lit("idle_pc", pc_write, 1);
        lit("idle_exmem_w", exmem_write, 1);

        // load-use on rs, then the hazard goes away
        go(7'b0010000, 8, 0, 8);
        lit("lu_pc", pc_write, 0);
        lit("lu_ifid_w", ifid_write, 0);
        lit("lu_idex_f", idex_flush, 1);
        go(7'b0000000, 8, 0, 8);
        lit("lu_after_pc", pc_write, 1);
        lit("lu_after_ifid_w", ifid_write, 1);
        // rt hazard counts only when rt is read
        go(7'b0110000, 1, 5, 5);
        lit("lu_rt_pc", pc_write, 0);
        go(7'b0010000, 1, 5, 5);
        lit("lu_rt_unused_pc", pc_write, 1);
        // $zero is never a hazard
        go(7'b0010000, 0, 0, 0);
        lit("r0_pc", pc_write, 1);
        lit("r0_idex_f", idex_flush, 0);
        // branch overrides load-use
        go(7'b0011000, 8, 0, 8);
        lit("br_pc", pc_write, 1);
        lit("br_ifid_f", ifid_flush, 1);
        lit("br_idex_f", idex_flush, 1);

        // memory wait for 3 cycles, released on the 4th
        do_reset();
        for (int i = 0; i < 3; i++) begin
            go(7'b0000010, 0, 0, 0);
            lit("mw_busy", busy, (i == 0) ? 0 : 1);
            lit("mw_memwb_f", memwb_flush, 1);
            lit("mw_exmem_w", exmem_write, 0);
        end
        go(7'b0000011, 0, 0, 0);
        lit("mw_rel_pc", pc_write, 1);
        lit("mw_rel_busy", busy, 1);
        go(7'b0000000, 0, 0, 0);
        lit("mw_after_busy", busy, 0);
`ifdef HAZARD_PERF_COUNTERS_EN
        lit("mw_stall_cnt", stall_cycle_count, 3);
`else
        lit("mw_stall_cnt_off", stall_cycle_count, 0);
`endif

        // mul/div freeze with ex_muldiv_start held
        do_reset();
        for (int i = 0; i < MDC; i++) begin
            go(7'b0000100, 0, 0, 0);
            lit("md_pc", pc_write, 0);
            lit("md_exmem_f", exmem_flush, 1);
        end
        go(7'b0000100, 0, 0, 0);
        lit("md_done", muldiv_done, 1);
        lit("md_done_pc", pc_write, 1);
        go(7'b0000000, 0, 0, 0);
        lit("md_after_done", muldiv_done, 0);
        lit("md_after_busy", busy, 0);

        // memory wait first, then the mul/div freeze
        do_reset();
        go(7'b0000110, 0, 0, 0);
        lit("mix_memwb_f", memwb_flush, 1);
        go(7'b0000110, 0, 0, 0);
        lit("mix_wait_busy", busy, 1);
        lit("mix_wait_exmem_f", exmem_flush, 0);
        go(7'b0000111, 0, 0, 0);
        lit("mix_rel_pc", pc_write, 1);
        for (int i = 0; i < MDC; i++) begin
            go(7'b0000100, 0, 0, 0);
            lit("mix_md_pc", pc_write, 0);
        end
        go(7'b0000100, 0, 0, 0);
        lit("mix_md_done", muldiv_done, 1);

        // reset in the middle of a mul/div freeze
        do_reset();
        go(7'b0000100, 0, 0, 0);
        go(7'b0000100, 0, 0, 0);
        go(7'b1000100, 0, 0, 0);
        lit("mid_rst_busy", busy, 0);
        lit("mid_rst_done", muldiv_done, 0);
        go(7'b0000000, 0, 0, 0);
        lit("mid_after_busy", busy, 0);
        lit("mid_after_done", muldiv_done, 0);
        lit("mid_after_pc", pc_write, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] c;
            c[6] = ($urandom_range(0, 99) == 0);
            c[5] = $urandom_range(0, 1);
            c[4] = $urandom_range(0, 1);
            c[3] = ($urandom_range(0, 5) == 0);
            c[2] = ($urandom_range(0, 7) == 0);
            c[1] = ($urandom_range(0, 2) == 0);
            c[0] = $urandom_range(0, 1);
            go(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
